ahb_bram_ctrl: RTL and testbench
================================

// Module: ahb_bram_ctrl
// PURPOSE
//  AHB-Lite slave that lets the Cortex-M0 bus access the dual-port Block_RAM holding the code/data image.
//  Converts AHB address/data phases into RAM port A byte-lane writes and port B reads (1-cycle read latency).
//  Zero-wait-state for legal transfers; forwards write data for back-to-back write->read to the same word.
//  Returns a two-cycle ERROR response for illegal size/alignment.
// PARAMETERS
//  ADDR_WIDTH  12  RAM word-address width; window = 2**(ADDR_WIDTH+2) bytes, upper HADDR bits ignored
// PORTS
//  HCLK        in   1             system clock; also clocks the RAM (clka)
//  HRESETn     in   1             reset, synchronous, active-low
//  HSEL        in   1             slave select
//  HADDR       in   32            byte address
//  HTRANS      in   2             transfer type; only NONSEQ(2)/SEQ(3) start an access
//  HSIZE       in   3             0=byte 1=half 2=word; >2 illegal
//  HWRITE      in   1             1=write
//  HREADY      in   1             bus ready (address phase accepted when 1)
//  HWDATA      in   32            write data (data phase)
//  HRDATA      out  32            read data (data phase)
//  HREADYOUT   out  1             slave ready
//  HRESP       out  1             0=OKAY 1=ERROR
//  bram_addra  out  ADDR_WIDTH    RAM write word address
//  bram_wea    out  4             RAM byte write enables
//  bram_dina   out  32            RAM write data
//  bram_addrb  out  ADDR_WIDTH    RAM read word address
//  bram_doutb  in   32            RAM read data, valid one cycle after bram_addrb
// BEHAVIOUR
//  - Accept: HSEL & HREADY & HTRANS[1]. Latch word addr, lane mask, HWRITE into data-phase regs.
//  - Lane mask: byte -> 1<<HADDR[1:0]; half -> 4'b0011<<HADDR[1:0]; word -> 4'b1111.
//  - Illegal: HSIZE>2, half with HADDR[0]=1, word with HADDR[1:0]!=0 -> ERROR, no RAM write.
//  - States: IDLE, WDATA, RDATA, ERR1, ERR2.
//    IDLE/WDATA/RDATA/ERR2 + accept legal write -> WDATA; legal read -> RDATA; illegal -> ERR1; else IDLE.
//    ERR1 -> ERR2 unconditionally (no accept in ERR1, HREADY=0). ERR2 transitions as IDLE.
//  - WDATA: bram_wea=latched mask, bram_addra=latched addr, bram_dina=HWDATA (comb); write at end of cycle.
//  - bram_wea=0 in every state other than WDATA.
//  - bram_addrb = HADDR[ADDR_WIDTH+1:2] combinationally every cycle; RDATA sees bram_doutb.
//  - Hazard: read accepted while in WDATA to the same word -> register fwd_mask/fwd_data;
//    in RDATA, HRDATA byte i = fwd_mask[i] ? fwd_data byte i : bram_doutb byte i. Else HRDATA=bram_doutb.
//  - HRDATA=0 outside RDATA. Read returns full word; master selects lanes.
//  - HREADYOUT: 0 in ERR1, else 1. HRESP: 1 in ERR1/ERR2, else 0.
//  - Address wraps modulo window; no out-of-range error.
//  - Reset (HRESETn=0 at edge): state=IDLE, HREADYOUT=1, HRESP=0, bram_wea=0, HRDATA=0, fwd_mask=0.
//    Reset during WDATA: write of that cycle still gated off if reset is low in that cycle (wea forced 0).
//  - IDLE/BUSY transfers and HSEL=0: OKAY, zero wait, no RAM activity, state -> IDLE.
// TESTING
//  1. Word write 0xDEADBEEF @0x10, then read @0x10 (back-to-back) -> HRDATA=0xDEADBEEF via forwarding, no waits.
//  2. Byte write 0xAA @0x21 over word 0x11223344, idle, read @0x20 -> HRDATA=0x1122AA44, bram_wea=4'b0010.
//  3. Half write 0x5566 @0x32, read @0x30 next cycle -> upper half forwarded, lower from RAM.
//  4. Word read @0x02 -> HREADYOUT 0 then 1, HRESP 1 both cycles, bram_wea stays 0, next transfer OKAY.
//  5. HSIZE=3 write -> ERROR pair, RAM unchanged; HTRANS=BUSY with HSEL=1 -> OKAY, no wea.
//  6. HRESETn low during WDATA -> wea=0, RAM unchanged, outputs at reset values next cycle.

Source files
------------

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave bridging the Cortex-M0 bus to a dual-port block RAM.
// Port A takes byte-lane writes in the write data phase; port B is read
// with one cycle of latency. Write data is forwarded when a read of the
// same word directly follows a write. Illegal size/alignment gives a
// two-cycle ERROR response with no RAM write.
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [3:0]            bram_wea,
    output logic [31:0]           bram_dina,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [31:0]           bram_doutb
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_RDATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_mask;
    logic [3:0]            r_fwdMask;
    logic [31:0]           r_fwdData;

    logic                  w_accept;
    logic                  w_legal;
    logic                  w_hazard;
    logic [3:0]            w_laneMask;
    logic [ADDR_WIDTH-1:0] w_wordAddr;
    logic                  w_unused;

    // Upper address bits fall outside the RAM window and HTRANS[0] only
    // distinguishes NONSEQ from SEQ, which this slave treats identically.
    assign w_unused = &{1'b0, HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    assign w_wordAddr = HADDR[ADDR_WIDTH+1:2];
    assign w_accept   = HSEL && HREADY && HTRANS[1] && (r_state != ST_ERR1);
    assign w_hazard   = (r_state == ST_WDATA) && w_accept && w_legal && !HWRITE
                        && (w_wordAddr == r_addr);

    // Decode the byte-lane mask and legality of the address-phase transfer.
    always_comb begin
        w_laneMask = 4'b0000;
        w_legal    = 1'b0;
        case (HSIZE)
            3'd0: begin
                w_laneMask = 4'b0001 << HADDR[1:0];
                w_legal    = 1'b1;
            end
            3'd1: begin
                w_laneMask = 4'b0011 << HADDR[1:0];
                w_legal    = ~HADDR[0];
            end
            3'd2: begin
                w_laneMask = 4'b1111;
                w_legal    = (HADDR[1:0] == 2'b00);
            end
            default: begin
                w_laneMask = 4'b0000;
                w_legal    = 1'b0;
            end
        endcase
    end

    // Next-state selection; ERR1 always moves on to ERR2, every other state
    // decides purely on the transfer presented in the current address phase.
    always_comb begin
        w_nextState = ST_IDLE;
        if (r_state == ST_ERR1) begin
            w_nextState = ST_ERR2;
        end else if (w_accept) begin
            if (!w_legal) begin
                w_nextState = ST_ERR1;
            end else if (HWRITE) begin
                w_nextState = ST_WDATA;
            end else begin
                w_nextState = ST_RDATA;
            end
        end
    end

    // State, data-phase address/mask and forwarding registers.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_mask    <= 4'b0000;
            r_fwdMask <= 4'b0000;
            r_fwdData <= 32'h0;
        end else begin
            r_state <= w_nextState;
            if (w_accept && w_legal) begin
                r_addr <= w_wordAddr;
                r_mask <= w_laneMask;
            end
            r_fwdMask <= w_hazard ? r_mask : 4'b0000;
            if (w_hazard) begin
                r_fwdData <= HWDATA;
            end
        end
    end

    // RAM port drive; the write enable is also gated by reset in its own
    // cycle so a write in flight is dropped when reset arrives.
    always_comb begin
        bram_addra = r_addr;
        bram_dina  = HWDATA;
        bram_addrb = w_wordAddr;
        bram_wea   = 4'b0000;
        if ((r_state == ST_WDATA) && HRESETn) begin
            bram_wea = r_mask;
        end
    end

    // Bus response and read data merge of forwarded lanes with RAM output.
    always_comb begin
        HREADYOUT = (r_state != ST_ERR1);
        HRESP     = (r_state == ST_ERR1) || (r_state == ST_ERR2);
        HRDATA    = 32'h0;
        if (r_state == ST_RDATA) begin
            for (int i = 0; i < 4; i++) begin
                HRDATA[i*8 +: 8] = r_fwdMask[i] ? r_fwdData[i*8 +: 8] : bram_doutb[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Directed bench for ahb_bram_ctrl with a behavioural dual-port RAM model.
module tb_ahb_bram_ctrl;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic        hready;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic [11:0] bramAddra;
    logic [3:0]  bramWea;
    logic [31:0] bramDina;
    logic [11:0] bramAddrb;
    logic [31:0] bramDoutb;

    logic [31:0] mem [0:4095];
    logic        ramLoaded = 1'b0;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic        rst;
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  size;
        logic        wr;
        logic        rdy;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expReady;
        logic        expResp;
        logic [3:0]  expWea;
        logic [11:0] expAddra;
    } vecT;

    vecT vecs[$];

    ahb_bram_ctrl #(.ADDR_WIDTH(12)) dut (
        .HCLK       (hclk),
        .HRESETn    (hresetn),
        .HSEL       (hsel),
        .HADDR      (haddr),
        .HTRANS     (htrans),
        .HSIZE      (hsize),
        .HWRITE     (hwrite),
        .HREADY     (hready),
        .HWDATA     (hwdata),
        .HRDATA     (hrdata),
        .HREADYOUT  (hreadyout),
        .HRESP      (hresp),
        .bram_addra (bramAddra),
        .bram_wea   (bramWea),
        .bram_dina  (bramDina),
        .bram_addrb (bramAddrb),
        .bram_doutb (bramDoutb)
    );

    always #5 hclk = ~hclk;

    // Dual-port RAM: byte-lane writes on port A, read-first registered port B.
    always @(posedge hclk) begin
        if (!ramLoaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
            mem[12'h008] <= 32'h11223344;
            mem[12'h00C] <= 32'hAABBCCDD;
            mem[12'h010] <= 32'h01020304;
            ramLoaded    <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bramWea[i]) mem[bramAddra][i*8 +: 8] <= bramDina[i*8 +: 8];
            end
        end
        bramDoutb <= mem[bramAddrb];
    end

    function automatic vecT mkVec(logic rst, logic sel, logic [31:0] addr, logic [1:0] trans,
                                  logic [2:0] size, logic wr, logic rdy, logic [31:0] wdata,
                                  logic [31:0] eRdata, logic eReady, logic eResp,
                                  logic [3:0] eWea, logic [11:0] eAddra);
        vecT v;
        v.rst = rst; v.sel = sel; v.addr = addr; v.trans = trans; v.size = size;
        v.wr = wr; v.rdy = rdy; v.wdata = wdata; v.expRdata = eRdata;
        v.expReady = eReady; v.expResp = eResp; v.expWea = eWea; v.expAddra = eAddra;
        return v;
    endfunction

    task automatic applyStimulus(input vecT v);
        hresetn = v.rst;
        hsel    = v.sel;
        haddr   = v.addr;
        htrans  = v.trans;
        hsize   = v.size;
        hwrite  = v.wr;
        hready  = v.rdy;
        hwdata  = v.wdata;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, idx, actual, expected);
        end
    endtask

    // Drive one cycle, sample mid-cycle, then advance past the next rising edge.
    task automatic runVector(input int idx, input vecT v);
        logic [11:0] expAddrb;
        applyStimulus(v);
        expAddrb = v.addr[13:2];
        #4;
        checkOutput("hrdata",    idx, hrdata,            v.expRdata);
        checkOutput("hreadyout", idx, {31'h0, hreadyout}, {31'h0, v.expReady});
        checkOutput("hresp",     idx, {31'h0, hresp},     {31'h0, v.expResp});
        checkOutput("wea",       idx, {28'h0, bramWea},   {28'h0, v.expWea});
        checkOutput("addrb",     idx, {20'h0, bramAddrb}, {20'h0, expAddrb});
        if (v.expWea != 4'b0000) begin
            checkOutput("addra", idx, {20'h0, bramAddra}, {20'h0, v.expAddra});
            checkOutput("dina",  idx, bramDina,           v.wdata);
        end
        @(posedge hclk);
        #1;
    endtask

    initial begin
        // Main directed table: one entry per bus cycle.
        // Word write @0x10 then back-to-back read of the same word.
        vecs.push_back(mkVec(1, 1, 32'h10, 2, 2, 1, 1, 32'h0,        32'h0,        1, 0, 4'h0, 12'h000));
        vecs.push_back(mkVec(1, 1, 32'h10, 2, 2, 0, 1, 32'hDEADBEEF, 32'h0,        1, 0, 4'hF, 12'h004));
        vecs.push_back(mkVec(1, 1, 32'h00, 0, 2, 0, 1, 32'h0,        32'hDEADBEEF, 1, 0, 4'h0, 12'h000));
        // Byte write 0xAA @0x21, idle, read @0x20.
        vecs.push_back(mkVec(1, 1, 32'h21, 2, 0, 1, 1, 32'h0,        32'h0,        1, 0, 4'h0, 12'h000));
        vecs.push_back(mkVec(1, 1, 32'h00, 0, 2, 0, 1, 32'hAAAAAAAA, 32'h0,        1, 0, 4'h2, 12'h008));
        vecs.push_back(mkVec(1, 1, 32'h20, 2, 2, 0, 1, 32'h0,        32'h0,        1, 0, 4'h0, 12'h000));
        vecs.push_back(mkVec(1, 1, 32'h00, 0, 2, 0, 1, 32'h0,        32'h1122AA44, 1, 0, 4'h0, 12'h000));
        // Half write 0x5566 @0x32, read @0x30 next cycle: partial forwarding.
        vecs.push_back(mkVec(1, 1, 32'h32, 2, 1, 1, 1, 32'h0,        32'h0,        1, 0, 4'h0, 12'h000));
        vecs.push_back(mkVec(1, 1, 32'h30, 2, 2, 0, 1, 32'h55660000, 32'h0,        1, 0, 4'hC, 12'h00C));
        vecs.push_back(mkVec(1, 1, 32'h00, 0, 2, 0, 1, 32'h0,        32'h5566CCDD, 1, 0, 4'h0, 12'h000));
        // Misaligned word read @0x02: ERROR pair, then an OKAY read.
        vecs.push_back(mkVec(1, 1, 32'h02, 2, 2, 0, 1, 32'h0,        32'h0,        1, 0, 4'h0, 12'h000));
        vecs.push_back(mkVec(1, 1, 32'h02, 2, 2, 0, 0, 32'h0,        32'h0,        0, 1, 4'h0, 12'h000));
        vecs.push_back(mkVec(1, 1, 32'h00, 0, 2, 0, 1, 32'h0,        32'h0,        1, 1, 4'h0, 12'h000));
        vecs.push_back(mkVec(1, 1, 32'h20, 2, 2, 0, 1, 32'h0,        32'h0,        1, 0, 4'h0, 12'h000));
        vecs.push_back(mkVec(1, 1, 32'h00, 0, 2, 0, 1, 32'h0,        32'h1122AA44, 1, 0, 4'h0, 12'h000));
        // HSIZE=3 write: ERROR pair; BUSY in ERR2 is OKAY afterwards, no write.
        vecs.push_back(mkVec(1, 1, 32'h10, 2, 3, 1, 1, 32'h0,        32'h0,        1, 0, 4'h0, 12'h000));
        vecs.push_back(mkVec(1, 1, 32'h10, 2, 3, 1, 0, 32'h12345678, 32'h0,        0, 1, 4'h0, 12'h000));
        vecs.push_back(mkVec(1, 1, 32'h10, 1, 2, 1, 1, 32'h12345678, 32'h0,        1, 1, 4'h0, 12'h000));
        vecs.push_back(mkVec(1, 1, 32'h00, 0, 2, 0, 1, 32'h0,        32'h0,        1, 0, 4'h0, 12'h000));
        // Upper address bits ignored: 0x12344020 aliases word 0x008.
        vecs.push_back(mkVec(1, 1, 32'h12344020, 2, 2, 0, 1, 32'h0,  32'h0,        1, 0, 4'h0, 12'h000));
        vecs.push_back(mkVec(1, 1, 32'h00, 0, 2, 0, 1, 32'h0,        32'h1122AA44, 1, 0, 4'h0, 12'h000));
        // Odd half read: ERROR pair; a legal read accepted in ERR2 proceeds.
        vecs.push_back(mkVec(1, 1, 32'h21, 2, 1, 0, 1, 32'h0,        32'h0,        1, 0, 4'h0, 12'h000));
        vecs.push_back(mkVec(1, 1, 32'h21, 2, 1, 0, 0, 32'h0,        32'h0,        0, 1, 4'h0, 12'h000));
        vecs.push_back(mkVec(1, 1, 32'h20, 2, 2, 0, 1, 32'h0,        32'h0,        1, 1, 4'h0, 12'h000));
        vecs.push_back(mkVec(1, 1, 32'h00, 0, 2, 0, 1, 32'h0,        32'h1122AA44, 1, 0, 4'h0, 12'h000));
        // Deselected write attempt: no RAM activity.
        vecs.push_back(mkVec(1, 0, 32'h20, 2, 2, 1, 1, 32'h0,        32'h0,        1, 0, 4'h0, 12'h000));
        vecs.push_back(mkVec(1, 1, 32'h00, 0, 2, 0, 1, 32'hFFFFFFFF, 32'h0,        1, 0, 4'h0, 12'h000));

        // Reset with an idle bus for two edges.
        applyStimulus(mkVec(0, 0, 32'h0, 0, 2, 0, 1, 32'h0, 32'h0, 1, 0, 4'h0, 12'h000));
        repeat (2) @(posedge hclk);
        #1;
        checkOutput("reset_hrdata",    -1, hrdata,              32'h0);
        checkOutput("reset_hreadyout", -1, {31'h0, hreadyout},  32'h1);
        checkOutput("reset_hresp",     -1, {31'h0, hresp},      32'h0);
        checkOutput("reset_wea",       -1, {28'h0, bramWea},    32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            runVector(i, vecs[i]);
        end

        // Reset asserted during the write data phase drops the write, then
        // a read of the same word still returns the preloaded value.
        runVector(100, mkVec(1, 1, 32'h40, 2, 2, 1, 1, 32'h0,        32'h0,        1, 0, 4'h0, 12'h000));
        runVector(101, mkVec(0, 1, 32'h00, 0, 2, 0, 1, 32'hCAFEF00D, 32'h0,        1, 0, 4'h0, 12'h000));
        runVector(102, mkVec(1, 1, 32'h00, 0, 2, 0, 1, 32'h0,        32'h0,        1, 0, 4'h0, 12'h000));
        runVector(103, mkVec(1, 1, 32'h40, 2, 2, 0, 1, 32'h0,        32'h0,        1, 0, 4'h0, 12'h000));
        runVector(104, mkVec(1, 1, 32'h00, 0, 2, 0, 1, 32'h0,        32'h01020304, 1, 0, 4'h0, 12'h000));

        // Final RAM image.
        checkOutput("mem_word04", 200, mem[12'h004], 32'hDEADBEEF);
        checkOutput("mem_word08", 201, mem[12'h008], 32'h1122AA44);
        checkOutput("mem_word0C", 202, mem[12'h00C], 32'h5566CCDD);
        checkOutput("mem_word10", 203, mem[12'h010], 32'h01020304);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
